// File: rtl/branch_resolve.sv
// branch_resolve: evaluates the branch condition of a B/BR instruction in ID
// against the Z/V/N flags. Flags produced by the ALU op currently in EX are
// forwarded ahead of the flag register. A taken branch registers the target,
// pulses br_taken_o/br_done_o and holds flush_o for FLUSH_LEN unstalled cycles.
// Saturating counters record resolved and taken branches.
module branch_resolve #(
    parameter int FLUSH_LEN = 2,   // 1..15
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic             br_reg_i,
    input  logic [2:0]       ccc_i,
    input  logic [15:0]      pc_plus2_i,
    input  logic [8:0]       imm9_i,
    input  logic [15:0]      rs_data_i,
    input  logic             Z_i,
    input  logic             V_i,
    input  logic             N_i,
    input  logic             ex_valid_i,
    input  logic [3:0]       ex_op_i,
    input  logic             Zalu_i,
    input  logic             Valu_i,
    input  logic             Nalu_i,
    output logic             br_taken_o,
    output logic             br_done_o,
    output logic [15:0]      target_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] tk_cnt_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_LEN - 1);

    state_t           state, state_next;
    logic [3:0]       remain, remain_next;
    logic             fwd_nv, fwd_z;
    logic             z_eff, v_eff, n_eff;
    logic             cond_met;
    logic             accept, taken;
    logic [15:0]      target_calc;

    // Select effective flags: ALU results override the flag register when EX writes them.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fwd_nv = 1'b0;
        fwd_z  = 1'b0;
        if (ex_valid_i) begin
            fwd_nv = (ex_op_i == 4'b0000) || (ex_op_i == 4'b0010);
            fwd_z  = !ex_op_i[3] && (ex_op_i != 4'b0001);
        end
        z_eff = fwd_z  ? Zalu_i : Z_i;
        n_eff = fwd_nv ? Nalu_i : N_i;
        v_eff = fwd_nv ? Valu_i : V_i;
    end

    // Evaluate the branch condition code against the effective flags.
    always_comb begin
        cond_met = 1'b0;
        case (ccc_i)
            3'b000:  cond_met = !z_eff;
            3'b001:  cond_met = z_eff;
            3'b010:  cond_met = !z_eff && !n_eff;
            3'b011:  cond_met = n_eff;
            3'b100:  cond_met = z_eff || !n_eff;
            3'b101:  cond_met = z_eff || n_eff;
            3'b110:  cond_met = v_eff;
            default: cond_met = 1'b1;
        endcase
    end

    // B adds the sign-extended word offset (wrapping mod 2^16); BR jumps to the register.
    assign target_calc = br_reg_i ? rs_data_i
                                  : pc_plus2_i + {{6{imm9_i[8]}}, imm9_i, 1'b0};

    // Branches are only accepted in IDLE; anything arriving during FLUSH is squashed.
    assign accept  = (state == IDLE) && br_valid_i && !stall_i;
    assign taken   = accept && cond_met;
    assign flush_o = (state == FLUSH);

    // Next-state logic: enter FLUSH on a taken branch, count down unstalled cycles.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        if (!stall_i) begin
            case (state)
                IDLE: begin
                    if (taken) begin
                        state_next  = FLUSH;
                        remain_next = FLUSH_LAST;
                    end
                end
                FLUSH: begin
                    if (remain == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        remain_next = remain - 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state and flush countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (rst) begin
            state  <= IDLE;
            remain <= 4'd0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    // Resolution pulses last one cycle; target only loads on a taken branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_done_o  <= 1'b0;
            br_taken_o <= 1'b0;
            target_o   <= 16'h0000;
        end else begin
            br_done_o  <= accept;
            br_taken_o <= taken;
            if (taken) begin
                target_o <= target_calc;
            end
        end
    end

    // Saturating statistics: stop at all-ones, at most +1 per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_o <= '0;
            tk_cnt_o <= '0;
        end else begin
            if (accept && (br_cnt_o != '1)) begin
                br_cnt_o <= br_cnt_o + CNT_W'(1);
            end
            if (taken && (tk_cnt_o != '1)) begin
                tk_cnt_o <= tk_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve. The stimulus process predicts each
// resolution from the branch rules and queues it; a monitor pops and compares
// whenever the DUT pulses br_done_o. flush_o is predicted cycle by cycle.
module tb_branch_resolve;

    localparam int FLEN = 2;
    localparam int CW   = 6;          // narrow counters so saturation is reachable
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst, stall_i, br_valid_i, br_reg_i;
    logic [2:0]    ccc_i;
    logic [15:0]   pc_plus2_i, rs_data_i;
    logic [8:0]    imm9_i;
    logic          Z_i, V_i, N_i, ex_valid_i, Zalu_i, Valu_i, Nalu_i;
    logic [3:0]    ex_op_i;
    logic          br_taken_o, br_done_o, flush_o;
    logic [15:0]   target_o;
    logic [CW-1:0] br_cnt_o, tk_cnt_o;

    branch_resolve #(.FLUSH_LEN(FLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_reg_i(br_reg_i), .ccc_i(ccc_i), .pc_plus2_i(pc_plus2_i),
        .imm9_i(imm9_i), .rs_data_i(rs_data_i), .Z_i(Z_i), .V_i(V_i), .N_i(N_i),
        .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .Zalu_i(Zalu_i),
        .Valu_i(Valu_i), .Nalu_i(Nalu_i), .br_taken_o(br_taken_o),
        .br_done_o(br_done_o), .target_o(target_o), .flush_o(flush_o),
        .br_cnt_o(br_cnt_o), .tk_cnt_o(tk_cnt_o)
    );

    typedef struct {
        logic        taken;
        logic [15:0] target;
        int          brc;
        int          tkc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int          flush_left = 0;   // unstalled cycles of flush still to come
    int          m_br = 0, m_tk = 0;
    logic [15:0] m_target = 16'h0000;
    int          flush_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch rules written straight from the condition table.
    function automatic bit model_taken(input logic [2:0] c, input bit z, v, n,
                                       input bit ex, input int op, input bit za, va, na);
        bit zf, vf, nf;
        zf = (ex && op < 8 && op != 1) ? za : z;
        nf = (ex && (op == 0 || op == 2)) ? na : n;
        vf = (ex && (op == 0 || op == 2)) ? va : v;
        case (c)
            3'd0: return !zf;
            3'd1: return zf;
            3'd2: return !zf && !nf;
            3'd3: return nf;
            3'd4: return zf || !nf;
            3'd5: return zf || nf;
            3'd6: return vf;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] model_target(input bit r, input int pc, input int imm, input int rs);
        int off;
        if (r) return 16'(rs);
        off = (imm >= 256) ? imm - 512 : imm;
        return 16'((pc + 2 * off) & 32'hFFFF);
    endfunction

    // One clock: check flush prediction, drive inputs, advance model for the coming edge.
    task automatic cycle(input bit v, r, input logic [2:0] c, input logic [15:0] pc,
                         input logic [8:0] imm, input logic [15:0] rs, input bit z, vv, n,
                         input bit ex, input logic [3:0] op, input bit za, va, na, st);
        exp_t e;
        @(negedge clk);
        check("flush_o", {31'd0, flush_o}, {31'd0, flush_left > 0});
        if (flush_o) flush_seen++;
        br_valid_i = v; br_reg_i = r; ccc_i = c; pc_plus2_i = pc; imm9_i = imm;
        rs_data_i = rs; Z_i = z; V_i = vv; N_i = n; ex_valid_i = ex; ex_op_i = op;
        Zalu_i = za; Valu_i = va; Nalu_i = na; stall_i = st;
        if (!st) begin
            if (flush_left > 0) begin
                flush_left--;
            end else if (v) begin
                e.taken = model_taken(c, z, vv, n, ex, int'(op), za, va, na);
                if (m_br < CMAX) m_br++;
                if (e.taken) begin
                    if (m_tk < CMAX) m_tk++;
                    m_target   = model_target(r, int'(pc), int'(imm), int'(rs));
                    flush_left = FLEN;
                end
                e.target = m_target;
                e.brc    = m_br;
                e.tkc    = m_tk;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 16'h0, 9'h0, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every resolution pulse against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (br_done_o) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("br_taken_o", {31'd0, br_taken_o}, {31'd0, e.taken});
                        check("target_o", {16'd0, target_o}, {16'd0, e.target});
                        check("br_cnt_o", {{(32-CW){1'b0}}, br_cnt_o}, e.brc);
                        check("tk_cnt_o", {{(32-CW){1'b0}}, tk_cnt_o}, e.tkc);
                    end
                end else if (br_taken_o) begin
                    check("taken_without_done", 32'd1, 32'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; stall_i = 0; br_valid_i = 0; br_reg_i = 0; ccc_i = 0;
        pc_plus2_i = 0; imm9_i = 0; rs_data_i = 0; Z_i = 0; V_i = 0; N_i = 0;
        ex_valid_i = 0; ex_op_i = 0; Zalu_i = 0; Valu_i = 0; Nalu_i = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_done", {31'd0, br_done_o}, 32'd0);
        check("rst_taken", {31'd0, br_taken_o}, 32'd0);
        check("rst_target", {16'd0, target_o}, 32'd0);
        check("rst_br_cnt", {{(32-CW){1'b0}}, br_cnt_o}, 32'd0);
        check("rst_tk_cnt", {{(32-CW){1'b0}}, tk_cnt_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // B EQ with Z=1: 0x0010 + (-2)*2 = 0x000C
        cycle(1, 0, 3'b001, 16'h0010, 9'h1FE, 16'h0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(1);
        check("dir1_taken", {31'd0, br_taken_o}, 32'd1);
        check("dir1_target", {16'd0, target_o}, 32'h000C);
        idle(3);

        // NEQ with forwarded Z=0 from ex_op 0010 -> taken
        cycle(1, 0, 3'b000, 16'h0100, 9'h004, 16'h0, 1, 0, 0, 1, 4'b0010, 0, 0, 0, 0);
        idle(1);
        check("dir2_taken", {31'd0, br_taken_o}, 32'd1);
        idle(3);

        // same with ex_op 0001: register Z=1 -> not taken
        cycle(1, 0, 3'b000, 16'h0100, 9'h004, 16'h0, 1, 0, 0, 1, 4'b0001, 0, 0, 0, 0);
        idle(1);
        check("dir3_done", {31'd0, br_done_o}, 32'd1);
        check("dir3_taken", {31'd0, br_taken_o}, 32'd0);
        check("dir3_flush", {31'd0, flush_o}, 32'd0);
        idle(1);

        // BR UNCOND -> 0xFFFE; B with wrap -> 0x0002
        cycle(1, 1, 3'b111, 16'h1234, 9'h0, 16'hFFFE, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(1);
        check("dir4_target", {16'd0, target_o}, 32'hFFFE);
        idle(3);
        cycle(1, 0, 3'b111, 16'hFFFE, 9'h002, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(1);
        check("dir5_target", {16'd0, target_o}, 32'h0002);
        idle(3);

        // taken branch, 3 stalled cycles during FLUSH with branches offered
        cycle(1, 0, 3'b111, 16'h0200, 9'h010, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        flush_seen = 0;
        repeat (3) cycle(1, 0, 3'b111, 16'h0300, 9'h0, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
        repeat (2) cycle(1, 0, 3'b111, 16'h0300, 9'h0, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(2);
        check("stall_flush_len", flush_seen, 32'd5);

        // back-to-back taken branches: the next one is accepted as flush drops
        repeat (6) cycle(1, 0, 3'b111, 16'h0400, 9'h008, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(3);

        // reset in the middle of FLUSH
        cycle(1, 0, 3'b111, 16'h0500, 9'h001, 16'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_flush", {31'd0, flush_o}, 32'd0);
        check("mid_rst_done", {31'd0, br_done_o}, 32'd0);
        check("mid_rst_taken", {31'd0, br_taken_o}, 32'd0);
        check("mid_rst_br_cnt", {{(32-CW){1'b0}}, br_cnt_o}, 32'd0);
        check("mid_rst_tk_cnt", {{(32-CW){1'b0}}, tk_cnt_o}, 32'd0);
        flush_left = 0; m_br = 0; m_tk = 0; m_target = 16'h0000;
        @(negedge clk);
        rst = 1'b0;

        // random traffic; long enough for both counters to saturate
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 1), 3'($urandom),
                  16'($urandom), 9'($urandom), 16'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  4'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 99) < 20);
        end
        idle(4);
        check("queue_drained", q.size(), 32'd0);
        check("final_br_cnt", {{(32-CW){1'b0}}, br_cnt_o}, m_br);
        check("final_tk_cnt", {{(32-CW){1'b0}}, tk_cnt_o}, m_tk);
        check("br_saturated", m_br, CMAX);
        check("tk_saturated", m_tk, CMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
